// File: rtl/param_tensor_core_if.sv
// Matrix-op request/result bundle between the register-file read ports and the tensor core.
// The requester drives master; the core drives slave.
interface param_tensor_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 3,
    parameter int LANES      = 2
);
    logic                                     should_start_tensor_core;
    logic [2:0]                               matrix_operation_select;
    logic                                     saturate_enable;
    logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]  tensor_core_input1;
    logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]  tensor_core_input2;
    logic [LANES-1:0][DATA_WIDTH-1:0]         tensor_core_output;
    logic [LANES-1:0]                         output_lane_valid;
    logic [$clog2(DIM*DIM)-1:0]               output_index;
    logic                                     busy;
    logic                                     done;
    logic                                     illegal_op;

    modport master (
        output should_start_tensor_core, matrix_operation_select, saturate_enable,
               tensor_core_input1, tensor_core_input2,
        input  tensor_core_output, output_lane_valid, output_index, busy, done, illegal_op
    );

    modport slave (
        input  should_start_tensor_core, matrix_operation_select, saturate_enable,
               tensor_core_input1, tensor_core_input2,
        output tensor_core_output, output_lane_valid, output_index, busy, done, illegal_op
    );
endinterface

// File: rtl/param_tensor_core.sv
// Streams DIM x DIM mul/add/sub/relu results LANES elements per beat, optional saturation.
// Latency: first beat one cycle after start is accepted, ceil(DIM*DIM/LANES) beats, done with the last.
// Backpressure: none; starts while busy are dropped and operands must stay stable for the whole op.
module param_tensor_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 3,
    parameter int LANES      = 2
) (
    input  logic               clock_in,
    input  logic               reset_n_in,
    param_tensor_core_if.slave tc
);
    localparam int N  = DIM * DIM;
    localparam int DW = DATA_WIDTH;
    localparam int MW = 2 * DW + $clog2(DIM);
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(N + LANES);

    localparam logic signed [MW-1:0] SAT_MAX = {{(MW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [MW-1:0] SAT_MIN = {{(MW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic logic signed [MW-1:0] sext(input logic [DW-1:0] x);
        return signed'({{(MW-DW){x[DW-1]}}, x});
    endfunction

    function automatic logic [DW-1:0] narrow(input logic signed [MW-1:0] v, input logic sat);
        if (sat && (v > SAT_MAX)) return SAT_MAX[DW-1:0];
        if (sat && (v < SAT_MIN)) return SAT_MIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    state_t                      r_state;
    logic [1:0]                  r_op;
    logic                        r_sat;
    logic [IW-1:0]               r_idx;
    logic [LANES-1:0][DW-1:0]    r_out;
    logic [LANES-1:0]            r_vld;
    logic [IW-1:0]               r_oidx;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_ill;

    logic [N-1:0][DW-1:0]        w_elem;
    logic [LANES-1:0][DW-1:0]    w_lane_dat;
    logic [LANES-1:0]            w_lane_vld;
    logic [LW-1:0]               w_base;
    logic                        w_last;

    // Every element is evaluated at full width in parallel; the beat logic picks LANES of them.
    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < DIM; gc++) begin : g_col
            logic signed [MW-1:0] w_wide;
            always_comb begin
                w_wide = '0;
                case (r_op)
                    2'b00: begin
                        for (int k = 0; k < DIM; k++)
                            w_wide = w_wide + sext(tc.tensor_core_input1[gr][k])
                                            * sext(tc.tensor_core_input2[k][gc]);
                    end
                    2'b01:   w_wide = sext(tc.tensor_core_input1[gr][gc])
                                    + sext(tc.tensor_core_input2[gr][gc]);
                    2'b10:   w_wide = tc.tensor_core_input1[gr][gc][DW-1] ? '0
                                    : sext(tc.tensor_core_input1[gr][gc]);
                    default: w_wide = sext(tc.tensor_core_input1[gr][gc])
                                    - sext(tc.tensor_core_input2[gr][gc]);
                endcase
            end
            assign w_elem[gr*DIM+gc] = narrow(w_wide, r_sat);
        end
    end

    assign w_base = LW'(r_idx);
    assign w_last = (w_base + LW'(LANES)) >= LW'(N);

    always_comb begin
        w_lane_dat = '0;
        w_lane_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_vld[k] = (w_base + LW'(k)) < LW'(N);
            for (int e = 0; e < N; e++)
                if ((w_base + LW'(k)) == LW'(e)) w_lane_dat[k] = w_elem[e];
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_sat   <= 1'b0;
            r_idx   <= '0;
            r_out   <= '0;
            r_vld   <= '0;
            r_oidx  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_vld  <= '0;
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tc.should_start_tensor_core) begin
                        if (tc.matrix_operation_select[2]) begin
                            r_done <= 1'b1;
                            r_ill  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_op    <= tc.matrix_operation_select[1:0];
                            r_sat   <= tc.saturate_enable;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_out  <= w_lane_dat;
                    r_vld  <= w_lane_vld;
                    r_oidx <= r_idx;
                    // Index parks on the last beat; the next accepted start clears it.
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(LANES);
                    end
                end
            endcase
        end
    end

    assign tc.tensor_core_output = r_out;
    assign tc.output_lane_valid  = r_vld;
    assign tc.output_index       = r_oidx;
    assign tc.busy               = r_busy;
    assign tc.done               = r_done;
    assign tc.illegal_op         = r_ill;
endmodule
